// File: rtl/centroid_update_unit.sv
// centroid_update_unit
// Recomputes every cluster centroid as the floor mean of its accumulated
// per-feature sums, using one serial restoring divider shared by all
// features. Each new centroid is written back to the centroid register file.
// The unit also reports whether every feature moved by no more than the
// programmed threshold, which tells the controller whether the pass converged.
module centroid_update_unit #(
    parameter int dataWidth    = 91,
    parameter int featureWidth = 13,
    parameter int featureNum   = 7,
    parameter int centroid_num = 8,
    parameter int sumWidth     = 24,
    parameter int cntWidth     = 11
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [featureWidth-1:0]           threshold,
    output logic [$clog2(centroid_num)-1:0]   acc_sel,
    input  logic [featureNum*sumWidth-1:0]    acc_sum_in,
    input  logic [cntWidth-1:0]               acc_cnt_in,
    input  logic [dataWidth-1:0]              cen_old_in,
    output logic                              cen_wr_en,
    output logic [$clog2(centroid_num)-1:0]   cen_wr_idx,
    output logic [dataWidth-1:0]              cen_wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              converged
);

    localparam int SEL_W = $clog2(centroid_num);
    localparam int F_W   = (featureNum > 1) ? $clog2(featureNum) : 1;
    localparam int BIT_W = $clog2(sumWidth);

    localparam logic [F_W-1:0]   F_LAST   = F_W'(featureNum - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(sumWidth - 1);
    localparam logic [SEL_W-1:0] C_LAST   = SEL_W'(centroid_num - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DIV   = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Control state
    logic [2:0]                   state_reg;
    logic [SEL_W-1:0]             c_reg;
    logic [F_W-1:0]               f_reg;
    logic [BIT_W-1:0]             bit_reg;
    logic [featureWidth-1:0]      thr_reg;
    logic                         conv_reg;

    // Datapath state
    logic [featureNum*sumWidth-1:0] sum_reg;
    logic [cntWidth-1:0]          cnt_reg;
    logic [dataWidth-1:0]         old_reg;
    logic [dataWidth-1:0]         new_reg;
    logic [cntWidth-1:0]          rem_reg;
    logic [sumWidth-1:0]          quo_reg;

    // Output registers
    logic                         busy_reg;
    logic                         done_reg;
    logic                         converged_reg;
    logic                         wr_en_reg;
    logic [SEL_W-1:0]             wr_idx_reg;
    logic [dataWidth-1:0]         wr_data_reg;

    // Divider step signals
    logic [cntWidth:0]            trial;
    logic                         q_bit;
    logic [cntWidth-1:0]          rem_next;
    logic [sumWidth-1:0]          quo_next;
    logic [featureWidth-1:0]      sat_q;
    logic [dataWidth-1:0]         new_next;
    logic [featureNum-1:0]        feat_ok;
    logic                         all_ok;

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when it fits. The quotient bits replace the
    // dividend bits in quo_reg as they are consumed, MSB first.
    always_comb begin
        trial    = {rem_reg, quo_reg[sumWidth-1]};
        q_bit    = (trial >= {1'b0, cnt_reg});
        rem_next = q_bit ? cntWidth'(trial - {1'b0, cnt_reg}) : trial[cntWidth-1:0];
        quo_next = {quo_reg[sumWidth-2:0], q_bit};
        // Only the final step's value is consumed; clamp to the feature range.
        sat_q    = (|quo_next[sumWidth-1:featureWidth]) ? {featureWidth{1'b1}}
                                                         : quo_next[featureWidth-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < featureNum; gi++) begin : g_feat
            logic [featureWidth-1:0] new_f;
            logic [featureWidth-1:0] old_f;
            logic [featureWidth-1:0] diff_f;

            // The feature currently being divided takes the fresh quotient;
            // the others keep what earlier passes through the divider left.
            assign new_next[gi*featureWidth +: featureWidth] =
                (f_reg == F_W'(gi)) ? sat_q : new_reg[gi*featureWidth +: featureWidth];

            // Convergence test uses the word being written in this cycle.
            assign new_f  = wr_data_reg[gi*featureWidth +: featureWidth];
            assign old_f  = old_reg[gi*featureWidth +: featureWidth];
            assign diff_f = (new_f >= old_f) ? (new_f - old_f) : (old_f - new_f);
            assign feat_ok[gi] = (diff_f <= thr_reg);
        end
    endgenerate

    assign all_ok = &feat_ok;

    // Pass sequencing: IDLE -> (LOAD -> [DIV] -> WRITE) per cluster -> DONE.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg     <= ST_IDLE;
            c_reg         <= '0;
            f_reg         <= '0;
            bit_reg       <= '0;
            thr_reg       <= '0;
            conv_reg      <= 1'b0;
            sum_reg       <= '0;
            cnt_reg       <= '0;
            old_reg       <= '0;
            new_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            converged_reg <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_idx_reg    <= '0;
            wr_data_reg   <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b0;
            // busy stays up through the done cycle and drops right after it,
            // which also keeps a start in the done cycle from being taken.
            if (done_reg) begin
                busy_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start && !busy_reg) begin
                        thr_reg       <= threshold;
                        c_reg         <= '0;
                        conv_reg      <= 1'b1;
                        converged_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    sum_reg <= acc_sum_in;
                    cnt_reg <= acc_cnt_in;
                    old_reg <= cen_old_in;
                    if (acc_cnt_in == '0) begin
                        // Empty cluster: keep the old centroid unchanged.
                        new_reg     <= cen_old_in;
                        wr_en_reg   <= 1'b1;
                        wr_idx_reg  <= c_reg;
                        wr_data_reg <= cen_old_in;
                        state_reg   <= ST_WRITE;
                    end else begin
                        f_reg     <= '0;
                        bit_reg   <= '0;
                        rem_reg   <= '0;
                        quo_reg   <= acc_sum_in[sumWidth-1:0];
                        state_reg <= ST_DIV;
                    end
                end

                ST_DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    bit_reg <= bit_reg + 1'b1;
                    if (bit_reg == BIT_LAST) begin
                        new_reg <= new_next;
                        bit_reg <= '0;
                        rem_reg <= '0;
                        if (f_reg == F_LAST) begin
                            wr_en_reg   <= 1'b1;
                            wr_idx_reg  <= c_reg;
                            wr_data_reg <= new_next;
                            state_reg   <= ST_WRITE;
                        end else begin
                            // Next feature's sum is the following slice; the
                            // shift keeps it at a fixed position.
                            f_reg   <= f_reg + 1'b1;
                            quo_reg <= sum_reg[sumWidth +: sumWidth];
                            sum_reg <= sum_reg >> sumWidth;
                        end
                    end
                end

                ST_WRITE: begin
                    conv_reg <= conv_reg & all_ok;
                    if (c_reg == C_LAST) begin
                        state_reg <= ST_DONE;
                    end else begin
                        c_reg     <= c_reg + 1'b1;
                        state_reg <= ST_LOAD;
                    end
                end

                ST_DONE: begin
                    done_reg      <= 1'b1;
                    converged_reg <= conv_reg;
                    state_reg     <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign acc_sel     = c_reg;
    assign cen_wr_en   = wr_en_reg;
    assign cen_wr_idx  = wr_idx_reg;
    assign cen_wr_data = wr_data_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign converged   = converged_reg;

endmodule

// File: tb/tb_centroid_update_unit.sv
// Testbench for centroid_update_unit: table-driven accumulator/register-file
// stand-in, an arithmetic reference model of a whole pass, and one compare
// process checking outputs every cycle of a pass.
module tb_centroid_update_unit;

    localparam int FW = 13;
    localparam int FN = 7;
    localparam int CN = 8;
    localparam int SW = 24;
    localparam int CW = 11;
    localparam int DW = 91;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [FW-1:0]   threshold;
    logic [2:0]      acc_sel;
    logic [FN*SW-1:0] acc_sum_in;
    logic [CW-1:0]   acc_cnt_in;
    logic [DW-1:0]   cen_old_in;
    logic            cen_wr_en;
    logic [2:0]      cen_wr_idx;
    logic [DW-1:0]   cen_wr_data;
    logic            busy;
    logic            done;
    logic            converged;

    always #5 clk = ~clk;

    centroid_update_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .threshold  (threshold),
        .acc_sel    (acc_sel),
        .acc_sum_in (acc_sum_in),
        .acc_cnt_in (acc_cnt_in),
        .cen_old_in (cen_old_in),
        .cen_wr_en  (cen_wr_en),
        .cen_wr_idx (cen_wr_idx),
        .cen_wr_data(cen_wr_data),
        .busy       (busy),
        .done       (done),
        .converged  (converged)
    );

    // Stimulus tables: per-cluster sums, counts and old centroid features
    logic [SW-1:0] t_sum [CN][FN];
    logic [CW-1:0] t_cnt [CN];
    logic [FW-1:0] t_old [CN][FN];

    always_comb begin
        acc_sum_in = '0;
        cen_old_in = '0;
        for (int f = 0; f < FN; f++) begin
            acc_sum_in[f*SW +: SW] = t_sum[acc_sel][f];
            cen_old_in[f*FW +: FW] = t_old[acc_sel][f];
        end
        acc_cnt_in = t_cnt[acc_sel];
    end

    // Reference model results
    logic [DW-1:0] exp_data [CN];
    int            exp_wr_cyc [CN];
    bit            exp_conv;
    int            exp_done_off;

    // Observations
    logic [DW-1:0] cap_data [CN];
    int            done_cyc;
    int            wr_count;
    int            run_id;

    int total;
    int bad;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [FW-1:0] feat(input logic [DW-1:0] d, input int f);
        return d[f*FW +: FW];
    endfunction

    // Whole-pass model: floor mean with saturation, empty clusters keep old,
    // convergence by absolute difference, timing from per-cluster costs.
    task automatic build_model(input logic [FW-1:0] thr);
        int t;
        int cost;
        longint q;
        longint o;
        longint d;
        t = 1;
        exp_conv = 1'b1;
        for (int c = 0; c < CN; c++) begin
            exp_data[c] = '0;
            for (int f = 0; f < FN; f++) begin
                o = longint'(t_old[c][f]);
                if (t_cnt[c] == 0) q = o;
                else begin
                    q = longint'(t_sum[c][f]) / longint'(t_cnt[c]);
                    if (q > 8191) q = 8191;
                end
                exp_data[c][f*FW +: FW] = q[FW-1:0];
                d = (q > o) ? (q - o) : (o - q);
                if (d > longint'(thr)) exp_conv = 1'b0;
            end
            cost = (t_cnt[c] == 0) ? 2 : (2 + FN * SW);
            exp_wr_cyc[c] = t + cost - 1;
            t = t + cost;
        end
        exp_done_off = t + 1;
    endtask

    // Per-cycle compare of a running pass against the model
    task automatic compare_loop();
        int  seen = 0;
        int  cyc = 0;
        int  ptr = 0;
        bit  act = 1'b0;
        bit  exp_wr;
        forever begin
            @(negedge clk);
            if (cen_wr_en) wr_count++;
            if (run_id != seen) begin
                seen = run_id;
                act = 1'b1;
                cyc = 0;
                ptr = 0;
                done_cyc = -1;
            end
            if (act) begin
                cyc++;
                if (done && done_cyc < 0) done_cyc = cyc;
                chk($sformatf("busy@%0d", cyc), busy, (cyc <= exp_done_off));
                chk($sformatf("done@%0d", cyc), done, (cyc == exp_done_off));
                if (ptr < CN) chk($sformatf("acc_sel@%0d", cyc), acc_sel, ptr);
                exp_wr = (ptr < CN) && (cyc == exp_wr_cyc[ptr]);
                chk($sformatf("wr_en@%0d", cyc), cen_wr_en, exp_wr);
                if (exp_wr) begin
                    chk($sformatf("wr_idx c%0d", ptr), cen_wr_idx, ptr);
                    chk($sformatf("wr_data c%0d", ptr), cen_wr_data, exp_data[ptr]);
                    $display("write c%0d cyc=%0d data=%0h", ptr, cyc, cen_wr_data);
                    cap_data[ptr] = cen_wr_data;
                    ptr++;
                end
                if (cyc == exp_done_off) begin
                    chk("converged", converged, exp_conv);
                    $display("pass end cyc=%0d converged=%0b", cyc, converged);
                    act = 1'b0;
                end
            end
        end
    endtask

    // One full pass with optional extra start pulses at offsets pa and pb
    task automatic do_pass(input logic [FW-1:0] thr, input int pa, input int pb);
        int n;
        int w0;
        build_model(thr);
        @(negedge clk);
        threshold = thr;
        start = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        run_id++;
        #1;
        start = 1'b0;
        threshold = ~thr;
        n = 0;
        while (n < exp_done_off + 1) begin
            @(negedge clk);
            n++;
            start = (n == pa) || (n == pb);
        end
        start = 1'b0;
        chk("busy_after_done", busy, 1'b0);
        chk("done_after_done", done, 1'b0);
        chk("writes_per_pass", wr_count - w0, CN);
    endtask

    task automatic fill_zero();
        for (int c = 0; c < CN; c++) begin
            t_cnt[c] = '0;
            for (int f = 0; f < FN; f++) begin
                t_old[c][f] = FW'($urandom_range(0, 8191));
                t_sum[c][f] = SW'($urandom);
            end
        end
    endtask

    task automatic fill_random(input bit all_nonzero, input bit near);
        int o;
        int dl;
        longint v;
        for (int c = 0; c < CN; c++) begin
            if (all_nonzero) t_cnt[c] = CW'($urandom_range(1, 2047));
            else begin
                case ($urandom_range(0, 3))
                    0: t_cnt[c] = '0;
                    1: t_cnt[c] = CW'($urandom_range(1, 8));
                    default: t_cnt[c] = CW'($urandom_range(1, 2047));
                endcase
            end
            for (int f = 0; f < FN; f++) begin
                o = int'($urandom_range(0, 8191));
                t_old[c][f] = FW'(o);
                if (near) begin
                    dl = int'($urandom_range(0, 6)) - 3;
                    v = (longint'(o) + longint'(dl)) * longint'(t_cnt[c]);
                    if (t_cnt[c] != 0) v = v + longint'($urandom_range(0, int'(t_cnt[c]) - 1));
                    if (v < 0) v = 0;
                    if (v > 16777215) v = 16777215;
                    t_sum[c][f] = v[SW-1:0];
                end else begin
                    t_sum[c][f] = SW'($urandom);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        total = 0;
        bad = 0;
        wr_count = 0;
        run_id = 0;
        done_cyc = -1;
        rst_n = 1'b1;
        start = 1'b0;
        threshold = '0;
        fill_zero();
        fork
            compare_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acc_sel", acc_sel, 0);
        chk("rst_wr_en", cen_wr_en, 0);
        chk("rst_wr_idx", cen_wr_idx, 0);
        chk("rst_wr_data", cen_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_converged", converged, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Exact mean: one populated cluster, the rest empty
        fill_zero();
        t_cnt[0] = 11'd4;
        for (int f = 0; f < FN; f++) t_sum[0][f] = 24'd400;
        do_pass(13'd0, 0, 0);
        chk("mean_done_cyc", done_cyc, 186);
        for (int f = 0; f < FN; f++) chk($sformatf("mean_f%0d", f), feat(cap_data[0], f), 100);

        // Floor rounding, saturation, maximum count
        fill_zero();
        t_cnt[2] = 11'd3;
        t_sum[2][0] = 24'd10;
        t_sum[2][1] = 24'd2;
        t_cnt[4] = 11'd1;
        t_sum[4][0] = 24'h100000;
        t_cnt[6] = 11'd2047;
        for (int f = 0; f < FN; f++) t_sum[6][f] = 24'd16766977;
        do_pass(13'd5, 0, 0);
        chk("floor_10_3", feat(cap_data[2], 0), 3);
        chk("floor_2_3", feat(cap_data[2], 1), 0);
        chk("saturate", feat(cap_data[4], 0), 8191);
        for (int f = 0; f < FN; f++) chk($sformatf("maxcnt_f%0d", f), feat(cap_data[6], f), 8191);

        // Convergence: one deviation of 3 in cluster 5 feature 6
        for (int c = 0; c < CN; c++) begin
            t_cnt[c] = 11'd1;
            for (int f = 0; f < FN; f++) begin
                t_old[c][f] = 13'd100;
                t_sum[c][f] = 24'd100;
            end
        end
        t_sum[5][6] = 24'd103;
        do_pass(13'd3, 0, 0);
        chk("conv_thr3", converged, 1);
        chk("all_nonzero_done_cyc", done_cyc, 1362);
        repeat (4) @(negedge clk);
        chk("conv_held", converged, 1);
        do_pass(13'd2, 0, 0);
        chk("conv_thr2", converged, 0);
        chk("dev_c5_f6", feat(cap_data[5], 6), 103);

        // Start pulses while busy and in the done cycle are ignored
        fill_random(1'b0, 1'b1);
        build_model(13'd3);
        do_pass(13'd3, 50, exp_done_off);

        // Reset during DIV of cluster 3 aborts the pass
        fill_random(1'b1, 1'b0);
        @(negedge clk);
        threshold = 13'd4;
        start = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (600) @(negedge clk);
        chk("abort_writes_before", wr_count - w0, 3);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("abort_acc_sel", acc_sel, 0);
        chk("abort_wr_en", cen_wr_en, 0);
        chk("abort_wr_idx", cen_wr_idx, 0);
        chk("abort_wr_data", cen_wr_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_converged", converged, 0);
        repeat (300) @(negedge clk);
        chk("abort_no_more_writes", wr_count - w0, 3);
        do_pass(13'd4, 0, 0);

        // Randomized passes
        for (int i = 0; i < 6; i++) begin
            fill_random(i[0], (i % 3) != 2);
            do_pass(FW'($urandom_range(0, 6)), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/centroid_update_unit.md
# centroid_update_unit

Downstream stage of the classification block in the k-means engine. After a classification pass it reads each cluster's per-feature accumulated sum and point count, computes the new centroid as the floor mean with a serial restoring divider, and writes it back to the centroid register file. It also compares each new centroid with the old one and reports whether the pass converged. It is controlled by the k-means controller through a start/busy/done handshake.

## Interface
- dataWidth, 91, centroid word width (featureNum × featureWidth)
- featureWidth, 13, unsigned feature width
- featureNum, 7, features per point
- centroid_num, 8, clusters; must be a power of 2
- sumWidth, 24, per-feature accumulator sum width
- cntWidth, 11, accumulator point-count width
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset; synchronous, active-high (1 = reset)
- start  in  1  one-cycle request to run an update pass
- threshold  in  featureWidth  per-feature convergence tolerance; sampled on the accepted start
- acc_sel  out  log2(centroid_num)  cluster index presented to the classification block and the core
- acc_sum_in  in  featureNum×sumWidth  sums for cluster acc_sel; feature i occupies [i*sumWidth +: sumWidth]; combinational, valid in the same cycle
- acc_cnt_in  in  cntWidth  point count for cluster acc_sel
- cen_old_in  in  dataWidth  current centroid acc_sel; feature i occupies [i*featureWidth +: featureWidth]
- cen_wr_en  out  1  one-cycle write strobe
- cen_wr_idx  out  log2(centroid_num)  cluster index being written
- cen_wr_data  out  dataWidth  new centroid, same packing as cen_old_in
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the pass completes
- converged  out  1  valid when done is high; held until the next accepted start

## Operation
- FSM states: IDLE, LOAD, DIV, WRITE, DONE.
- **IDLE**
  - start=1 is accepted: latch threshold, set c=0, set conv=1, clear converged, go to LOAD.
  - start is ignored in every other state.
- **LOAD** (1 cycle)
  - acc_sel=c. Latch acc_sum_in, acc_cnt_in and cen_old_in.
  - If cnt==0, the result is the old centroid: go to WRITE.
  - Otherwise set f=0 and go to DIV.
- **DIV**
  - Unsigned restoring division of sum[f] by cnt, one quotient bit per cycle, MSB first. sumWidth cycles per feature.
  - The quotient is floor(sum/cnt). Its low featureWidth bits form new[f].
  - If the quotient is ≥ 2^featureWidth, new[f] saturates to 2^featureWidth−1.
  - After the last bit: if f==featureNum−1, go to WRITE; otherwise f++ and start the next feature in the next cycle, with no gap.
- **WRITE** (1 cycle)
  - cen_wr_en=1, cen_wr_idx=c, cen_wr_data = assembled new centroid.
  - conv &= (|new[f]−old[f]| ≤ threshold) for every f. The difference is taken as an unsigned absolute value.
  - If c==centroid_num−1, go to DONE; otherwise c++ and go to LOAD.
- **DONE** (1 cycle)
  - done=1, converged=conv. Go to IDLE.
- A zero-count cluster keeps its old value and counts as converged.
- acc_sel always equals c and stays stable from LOAD through WRITE.
- Reset in any state forces IDLE and clears all state. No write is issued in the reset cycle. A partially written pass is not rolled back.

## Timing
- Reset values: acc_sel=0, cen_wr_en=0, cen_wr_idx=0, cen_wr_data=0, busy=0, done=0, converged=0.
- Start accepted at edge k:
  - busy=1 from cycle k+1.
  - First LOAD occupies cycle k+1.
- Cluster cost:
  - cnt≠0: 1 + featureNum×sumWidth + 1 = 170 cycles.
  - cnt==0: 2 cycles.
- done is high exactly 1 + Σ(cluster costs) cycles after k+1.
  - All counts non-zero: done in cycle k+1362 (1360 + 1).
  - All counts zero: done in cycle k+18.
- busy falls in the same cycle that done is high; busy=0 in the cycle after done.
- A new start is accepted in the cycle after done at the earliest.
- Writes occur strictly in cluster order 0..centroid_num−1, one write per cluster, never back-to-back without an intervening LOAD.

## Test plan
- **Exact mean:** cluster 0 has cnt=4 and all sums=400; others have cnt=0. Expect write idx0 with every feature=100, seven writes of the old values, and done at k+1+170+14+1.
- **Floor rounding:** sum=10, cnt=3 → feature=3. sum=2, cnt=3 → 0.
- **Convergence:**
  - old=100, new=103, threshold=3 → converged=1.
  - threshold=2 → converged=0, with a single deviation in cluster 5 feature 6.
- **Saturation:** sum=2^20, cnt=1 → feature=8191.
- **Handshake and reset:** start pulsed while busy is ignored (exactly 8 writes). rst_n=1 during DIV of cluster 3 → next cycle IDLE, all outputs at reset values, no further writes. A following start completes a full pass.
- **Max count:** cnt=2047 and sums=2047×8191 → every feature=8191, no saturation flag path taken, result exact.
